// File: rtl/dmem_responder_if.sv
// Request/response channel between the datapath (master) and the data-memory
// responder (slave): valid/ready request, single-cycle response strobe.
interface dmem_responder_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic          req_byte;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;

   modport master (
      output req_valid, req_we, req_byte, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_byte, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with word/byte stores, aligned-word loads and a
// programmable number of wait states between accept and response.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1,
   parameter int AW          = 32
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int IW      = $clog2(DEPTH_WORDS);
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          lat_we;
   logic          lat_byte;
   logic [AW-1:0] lat_addr;
   logic [31:0]   lat_wdata;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept;
   logic          go_resp;
   logic          mem_we;
   logic          acc_we;
   logic          acc_byte;
   logic [AW-1:0] acc_addr;
   logic [31:0]   acc_wdata;
   logic [IW-1:0] acc_idx;
   logic [1:0]    acc_lane;
   logic          acc_err;

   assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

   // With no wait states RESP is entered on the accept edge itself, so the
   // access must use the live request rather than the not-yet-latched copy.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      acc_we    = lat_we;
      acc_byte  = lat_byte;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      if (state == IDLE) begin
         acc_we    = bus.req_we;
         acc_byte  = bus.req_byte;
         acc_addr  = bus.req_addr;
         acc_wdata = bus.req_wdata;
      end
   end

   assign acc_idx  = acc_addr[IW+1:2];
   assign acc_lane = acc_addr[1:0];
   assign acc_err  = (|acc_addr[AW-1:IW+2]) || (!acc_byte && (acc_lane != 2'b00));
   assign go_resp  = NO_WAIT ? accept : ((state == WAIT) && (cnt == 4'd1));
   assign mem_we   = go_resp && acc_we && !acc_err;

   // NOTE: the RAM array is deliberately left out of reset; only control state is reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (acc_byte) mem[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_wdata[7:0];
         else          mem[acc_idx] <= acc_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_we        <= 1'b0;
         lat_byte      <= 1'b0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         if (go_resp) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= acc_err;
            if (!acc_we) bus.rsp_rdata <= acc_err ? 32'h0 : mem[acc_idx];
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we        <= bus.req_we;
                  lat_byte      <= bus.req_byte;
                  lat_addr      <= bus.req_addr;
                  lat_wdata     <= bus.req_wdata;
                  bus.req_ready <= 1'b0;
                  if (NO_WAIT) begin
                     state <= RESP;
                  end else begin
                     cnt   <= 4'(WAIT_CYCLES);
                     state <= WAIT;
                  end
               end else begin
                  bus.req_ready <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: table of load/store vectors on a WAIT_CYCLES=1 instance, plus
// latency sequences on WAIT_CYCLES=0/3 instances and a reset-during-WAIT case.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]  sel = 2'd0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        req_byte = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   dmem_responder_if #(.AW(32)) bus0 ();
   dmem_responder_if #(.AW(32)) bus1 ();
   dmem_responder_if #(.AW(32)) bus2 ();

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1), .AW(32)) dut_w1 (.clk(clk), .reset(reset), .bus(bus0));
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .AW(32)) dut_w0 (.clk(clk), .reset(reset), .bus(bus1));
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .AW(32)) dut_w3 (.clk(clk), .reset(reset), .bus(bus2));

   assign bus0.req_valid = req_valid && (sel == 2'd0);
   assign bus1.req_valid = req_valid && (sel == 2'd1);
   assign bus2.req_valid = req_valid && (sel == 2'd2);
   assign bus0.req_we = req_we;      assign bus1.req_we = req_we;      assign bus2.req_we = req_we;
   assign bus0.req_byte = req_byte;  assign bus1.req_byte = req_byte;  assign bus2.req_byte = req_byte;
   assign bus0.req_addr = req_addr;  assign bus1.req_addr = req_addr;  assign bus2.req_addr = req_addr;
   assign bus0.req_wdata = req_wdata; assign bus1.req_wdata = req_wdata; assign bus2.req_wdata = req_wdata;

   assign ready     = (sel == 2'd0) ? bus0.req_ready : (sel == 2'd1) ? bus1.req_ready : bus2.req_ready;
   assign rsp_valid = (sel == 2'd0) ? bus0.rsp_valid : (sel == 2'd1) ? bus1.rsp_valid : bus2.rsp_valid;
   assign rsp_rdata = (sel == 2'd0) ? bus0.rsp_rdata : (sel == 2'd1) ? bus1.rsp_rdata : bus2.rsp_rdata;
   assign rsp_err   = (sel == 2'd0) ? bus0.rsp_err   : (sel == 2'd1) ? bus1.rsp_err   : bus2.rsp_err;

   typedef struct {
      logic        we;
      logic        byt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge where req_ready is back high.
   task automatic xfer(input logic [1:0] s, input logic we, input logic byt,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int low, output int pulses, output int acc_cyc);
      int guard;
      bit got;
      sel = s; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      guard = 0;
      while (!ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      req_wdata = 32'hFFFF_FFFF;
      req_addr  = 32'h0000_0001;
      lat = 0; low = 0; pulses = 0; got = 1'b0;
      rdata = 'x; err = 1'bx;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!got) lat++;
         if (rsp_valid) begin
            got = 1'b1;
            pulses++;
            rdata = rsp_rdata;
            err   = rsp_err;
         end
         if (!ready) low++;
         else if (got) break;
      end
      if (!got) lat = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, low, pulses, acc_a, acc_b, seen;

      vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h20,  32'h11223344, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 32'h22,  32'h000000AB, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h11AB3344, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h23,  32'h0,        32'h11AB3344, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 32'h21,  32'hFFFFFF77, 32'h11AB3344, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h11AB7744, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h04,  32'h55667788, 32'h11AB7744, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h06,  32'h0,        32'h00000000, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 32'h05,  32'h99999999, 32'h00000000, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 32'h04,  32'h0,        32'h55667788, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'h00,  32'hA5A5A5A5, 32'h55667788, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 32'h100, 32'h12345678, 32'h55667788, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 32'h00,  32'h0,        32'hA5A5A5A5, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 32'hFC,  32'h0F0F0F0F, 32'hA5A5A5A5, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 32'hFC,  32'h0,        32'h0F0F0F0F, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 32'h101, 32'h0,        32'h00000000, 1'b1};
      vecs[18] = '{1'b1, 1'b0, 32'h30,  32'h00000000, 32'h00000000, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 32'h30,  32'h0,        32'h00000000, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 32'hFF,  32'h0,        32'h0F0F0F0F, 1'b0};

      // Reset state
      #2 reset = 1'b0;
      @(negedge clk);
      check("reset_ready", 32'(bus0.req_ready), 32'd0);
      check("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
      check("reset_rdata", bus0.rsp_rdata, 32'h0);
      check("reset_err", 32'(bus0.rsp_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1 check("ready_low_at_release", 32'(bus0.req_ready), 32'd0);
      @(negedge clk);
      check("ready_after_release", 32'(bus0.req_ready), 32'd1);

      // Table-driven vectors on the WAIT_CYCLES=1 instance
      for (int i = 0; i < NV; i++) begin
         xfer(2'd0, vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata, rd, er, lat, low, pulses, acc_a);
         check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
         check($sformatf("v%0d_ready_low", i), 32'(low), 32'd2);
         check($sformatf("v%0d_pulses", i), 32'(pulses), 32'd1);
      end

      // WAIT_CYCLES=0: one-cycle latency, accepts every 2 cycles
      xfer(2'd1, 1'b1, 1'b0, 32'h08, 32'h13579BDF, rd, er, lat, low, pulses, acc_a);
      check("w0_store_latency", 32'(lat), 32'd1);
      check("w0_store_err", 32'(er), 32'd0);
      xfer(2'd1, 1'b0, 1'b0, 32'h08, 32'h0, rd, er, lat, low, pulses, acc_b);
      check("w0_load_latency", 32'(lat), 32'd1);
      check("w0_load_rdata", rd, 32'h13579BDF);
      check("w0_accept_spacing", 32'(acc_b - acc_a), 32'd2);
      check("w0_ready_low", 32'(low), 32'd1);

      // WAIT_CYCLES=3: four-cycle latency
      xfer(2'd2, 1'b1, 1'b0, 32'h0C, 32'h2468ACE0, rd, er, lat, low, pulses, acc_a);
      check("w3_store_latency", 32'(lat), 32'd4);
      xfer(2'd2, 1'b0, 1'b0, 32'h0C, 32'h0, rd, er, lat, low, pulses, acc_b);
      check("w3_load_latency", 32'(lat), 32'd4);
      check("w3_ready_low", 32'(low), 32'd4);
      check("w3_load_rdata", rd, 32'h2468ACE0);
      check("w3_accept_spacing", 32'(acc_b - acc_a), 32'd5);

      // Reset while a store is in WAIT abandons it
      sel = 2'd0; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
      req_valid = 1'b1;
      seen = 0;
      while (!ready && seen < 40) begin
         @(negedge clk);
         seen++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_ready", 32'(bus0.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
      check("rst_rdata", bus0.rsp_rdata, 32'h0);
      check("rst_err", 32'(bus0.rsp_err), 32'd0);
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus0.rsp_valid) seen++;
      end
      reset = 1'b1;
      #1 check("rst_release_ready_low", 32'(bus0.req_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus0.rsp_valid) seen++;
      end
      check("rst_no_response", 32'(seen), 32'd0);
      check("rst_ready_back", 32'(bus0.req_ready), 32'd1);
      xfer(2'd0, 1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat, low, pulses, acc_a);
      check("rst_load_rdata", rd, 32'h00000000);
      check("rst_load_err", 32'(er), 32'd0);
      check("rst_load_latency", 32'(lat), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
